inst_cache_sa: RTL and testbench

Parametrised set-associative instruction cache, successor to the direct-mapped `inst_cache`. It sits between the core fetch port (`inst_addr_o` / `inst_data_i` / `inst_valid_i`) and the line-refill bus (`addr_o` / `data_i` / `rd_o` / `ack_i`). It adds 1- or 2-way associativity with per-set LRU, a parametrised line size and set count, a `mem_fc` flush that correctly kills an in-flight refill, and hit/miss counters.

---
 rtl/inst_cache_sa.sv | 198 +++++++++++++++++++
 tb/tb_inst_cache_sa.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_cache_sa.sv
// inst_cache_sa: set-associative (1- or 2-way) instruction cache with per-set
// LRU, configurable line size and set count, refill kill on flush, and
// hit/miss counters.
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   inst_addr_i              fetch address (bits [1:0] ignored)
//   inst_data_o/inst_valid_o combinational hit word / hit flag
//   mem_fc                   flush: clears valid and LRU bits, kills a refill
//   addr_o, rd_o             line refill request (held until ack_i)
//   data_i, ack_i            refill line (word k at [32k+31:32k]) / data strobe
//   hit_count_o              hit cycles seen in IDLE (wrapping)
//   miss_count_o             refills started (wrapping)

// One way of the cache: valid bits, tags and line data for every set.
module inst_cache_sa_way #(
  parameter int SETS       = 8,
  parameter int LINE_WORDS = 8,
  parameter int IDX        = 3,
  parameter int TAG        = 24,
  parameter int WSEL       = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    fill,
  input  logic [IDX-1:0]          fill_idx,
  input  logic [TAG-1:0]          fill_tag,
  input  logic [32*LINE_WORDS-1:0] fill_line,
  input  logic [IDX-1:0]          lk_idx,
  input  logic [TAG-1:0]          lk_tag,
  input  logic [WSEL-1:0]         lk_wsel,
  output logic                    lk_valid,
  output logic                    lk_match,
  output logic [31:0]             lk_word
);
  logic [SETS-1:0]                        valid_q;
  logic [SETS-1:0][TAG-1:0]               tag_q;
  logic [SETS-1:0][LINE_WORDS-1:0][31:0]  data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        valid_q <= '0;
    else if (flush) valid_q <= '0;
    else if (fill)  valid_q[fill_idx] <= 1'b1;
  end

  // Tags and line data carry no reset; valid bits gate every use of them.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= fill_line;
    end
  end

  assign lk_valid = valid_q[lk_idx];
  assign lk_match = (tag_q[lk_idx] == lk_tag);
  assign lk_word  = data_q[lk_idx][lk_wsel];
endmodule

module inst_cache_sa #(
  parameter int SETS       = 8,
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              inst_addr_i,
  output logic [31:0]              inst_data_o,
  output logic                     inst_valid_o,
  input  logic                     mem_fc,
  output logic [31:0]              addr_o,
  input  logic [32*LINE_WORDS-1:0] data_i,
  output logic                     rd_o,
  input  logic                     ack_i,
  output logic [31:0]              hit_count_o,
  output logic [31:0]              miss_count_o
);
  localparam int OFF  = $clog2(LINE_WORDS) + 2;
  localparam int IDX  = $clog2(SETS);
  localparam int TAG  = 32 - IDX - OFF;
  localparam int WSEL = OFF - 2;

  typedef enum logic [1:0] {S_IDLE, S_REFILL, S_KILL} state_t;
  state_t state_q, state_d;

  logic [IDX-1:0]  lk_idx, lat_idx;
  logic [TAG-1:0]  lk_tag, lat_tag;
  logic [WSEL-1:0] lk_wsel;
  logic            unused_bits;

  assign lk_idx      = inst_addr_i[IDX+OFF-1:OFF];
  assign lk_tag      = inst_addr_i[31:IDX+OFF];
  assign lk_wsel     = inst_addr_i[OFF-1:2];
  assign unused_bits = ^inst_addr_i[1:0];
  // The latched line address is the single source of the refill set/tag.
  assign lat_idx     = addr_o[IDX+OFF-1:OFF];
  assign lat_tag     = addr_o[31:IDX+OFF];

  logic [WAYS-1:0]        way_valid, way_match;
  logic [WAYS-1:0][31:0]  way_word;
  logic [SETS-1:0]        lru_q;     // per set: way to evict next
  logic                   victim_q, victim_d;
  logic                   hit_any, hit_way, hit, miss, fill_en;
  logic [31:0]            hit_word;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    localparam logic WID = 1'(w);
    inst_cache_sa_way #(
      .SETS(SETS), .LINE_WORDS(LINE_WORDS), .IDX(IDX), .TAG(TAG), .WSEL(WSEL)
    ) u_way (
      .clk      (clk),
      .rst      (rst),
      .flush    (mem_fc),
      .fill     (fill_en && (victim_q == WID)),
      .fill_idx (lat_idx),
      .fill_tag (lat_tag),
      .fill_line(data_i),
      .lk_idx   (lk_idx),
      .lk_tag   (lk_tag),
      .lk_wsel  (lk_wsel),
      .lk_valid (way_valid[w]),
      .lk_match (way_match[w]),
      .lk_word  (way_word[w])
    );
  end

  always_comb begin
    hit_any  = 1'b0;
    hit_way  = 1'b0;
    hit_word = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (way_valid[w] && way_match[w]) begin
        hit_any  = 1'b1;
        hit_way  = 1'(w);
        hit_word = way_word[w];
      end
    end
  end

  // First invalid way wins (descending scan leaves way 0 as the preference);
  // with every way valid fall back to the set's LRU bit.
  always_comb begin
    victim_d = (WAYS == 2) ? lru_q[lk_idx] : 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!way_valid[w]) victim_d = 1'(w);
    end
  end

  assign hit     = (state_q == S_IDLE) && !mem_fc && hit_any;
  assign miss    = (state_q == S_IDLE) && !mem_fc && !hit_any;
  // A flush in the ack cycle discards the line.
  assign fill_en = (state_q == S_REFILL) && ack_i && !mem_fc;

  assign inst_valid_o = hit;
  assign inst_data_o  = hit ? hit_word : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (miss) state_d = S_REFILL;
      S_REFILL: if (ack_i) state_d = S_IDLE;
                else if (mem_fc) state_d = S_KILL;
      S_KILL:   if (ack_i) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_o         <= 1'b0;
      addr_o       <= '0;
      victim_q     <= 1'b0;
      hit_count_o  <= '0;
      miss_count_o <= '0;
    end else begin
      if (miss) begin
        addr_o       <= {inst_addr_i[31:OFF], {OFF{1'b0}}};
        victim_q     <= victim_d;
        rd_o         <= 1'b1;
        miss_count_o <= miss_count_o + 32'd1;
      end
      if ((state_q != S_IDLE) && ack_i) rd_o <= 1'b0;
      if (hit) hit_count_o <= hit_count_o + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          lru_q <= '0;
    else if (mem_fc)  lru_q <= '0;
    else if (hit)     lru_q[lk_idx]  <= ~hit_way;
    else if (fill_en) lru_q[lat_idx] <= ~victim_q;
  end
endmodule

// File: tb/tb_inst_cache_sa.sv
// Directed bench for inst_cache_sa (defaults: 8 sets, 2 ways, 8-word lines).
// Line pattern: word at address A is 32'hA000_0000 | A, except where a test
// overrides a word.
module tb_inst_cache_sa;
  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  inst_addr_i;
  logic [31:0]  inst_data_o;
  logic         inst_valid_o;
  logic         mem_fc;
  logic [31:0]  addr_o;
  logic [255:0] data_i;
  logic         rd_o;
  logic         ack_i;
  logic [31:0]  hit_count_o;
  logic [31:0]  miss_count_o;

  int n_chk  = 0;
  int n_pass = 0;

  inst_cache_sa dut (
    .clk(clk), .rst(rst), .inst_addr_i(inst_addr_i), .inst_data_o(inst_data_o),
    .inst_valid_o(inst_valid_o), .mem_fc(mem_fc), .addr_o(addr_o), .data_i(data_i),
    .rd_o(rd_o), .ack_i(ack_i), .hit_count_o(hit_count_o), .miss_count_o(miss_count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] mk_line(input logic [31:0] base);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = 32'hA000_0000 | (base + 32'(4 * k));
    return l;
  endfunction

  // Miss on a, request check, ack after lat extra cycles, hit check after.
  task automatic fill(input logic [31:0] a, input int lat);
    inst_addr_i = a;
    #1;
    chk("fill_miss", inst_valid_o, 1'b0);
    cyc;
    chk("fill_rd", rd_o, 1'b1);
    chk("fill_addr", addr_o, a & ~32'h1F);
    repeat (lat) cyc;
    ack_i = 1'b1; data_i = mk_line(a & ~32'h1F);
    cyc;
    ack_i = 1'b0;
    #1;
    chk("fill_rd_drop", rd_o, 1'b0);
    chk("fill_hit", inst_valid_o, 1'b1);
    chk("fill_data", inst_data_o, 32'hA000_0000 | a);
  endtask

  initial begin
    logic [255:0] line1;
    rst = 1'b1; inst_addr_i = 32'h40; mem_fc = 1'b0; ack_i = 1'b0; data_i = '0;
    repeat (2) cyc;
    chk("rst_rd", rd_o, 1'b0);
    chk("rst_addr", addr_o, 32'h0);
    chk("rst_hits", hit_count_o, 32'h0);
    chk("rst_miss", miss_count_o, 32'h0);
    chk("rst_vld", inst_valid_o, 1'b0);
    chk("rst_data", inst_data_o, 32'h0);

    // Cold miss on 0x40; the fetch moves to 0x48 (word 2) while refilling.
    rst = 1'b0;
    #1;
    chk("cold_miss", inst_valid_o, 1'b0);
    cyc;
    chk("cold_rd", rd_o, 1'b1);
    chk("cold_mcnt", miss_count_o, 32'd1);
    inst_addr_i = 32'h48;
    for (int i = 0; i < 7; i++) begin
      chk("cold_rd_hold", rd_o, 1'b1);
      chk("cold_addr", addr_o, 32'h40);
      cyc;
    end
    line1 = mk_line(32'h40);
    line1[95:64] = 32'hDEADBEEF;
    ack_i = 1'b1; data_i = line1;
    cyc;
    ack_i = 1'b0;
    #1;
    chk("cold_rd_drop", rd_o, 1'b0);
    chk("cold_vld", inst_valid_o, 1'b1);
    chk("cold_data", inst_data_o, 32'hDEADBEEF);
    chk("cold_mcnt2", miss_count_o, 32'd1);

    // Sequential hits; the post-fill cycle above already counted one hit.
    for (int i = 0; i < 8; i++) begin
      cyc;
      inst_addr_i = 32'h40 + 32'(4 * i);
      #1;
      chk("seq_vld", inst_valid_o, 1'b1);
      chk("seq_data", inst_data_o, (i == 2) ? 32'hDEADBEEF : (32'hA000_0040 + 32'(4 * i)));
      chk("seq_rd", rd_o, 1'b0);
    end
    cyc;
    chk("seq_hcnt", hit_count_o, 32'd9);

    // 2-way conflict in set 0: 0x000 -> way0, 0x100 -> way1, touch 0x000,
    // then 0x200 must evict way1.
    fill(32'h000, 2);
    fill(32'h100, 1);
    inst_addr_i = 32'h000;
    #1;
    chk("touch_000", inst_valid_o, 1'b1);
    cyc;
    fill(32'h200, 0);
    inst_addr_i = 32'h000;
    #1;
    chk("keep_000", inst_valid_o, 1'b1);
    chk("keep_000_d", inst_data_o, 32'hA000_0000);
    cyc;
    inst_addr_i = 32'h100;
    #1;
    chk("evict_100", inst_valid_o, 1'b0);
    cyc;
    chk("evict_rd", rd_o, 1'b1);
    chk("evict_addr", addr_o, 32'h100);
    ack_i = 1'b1; data_i = mk_line(32'h100);
    cyc;
    ack_i = 1'b0;
    #1;
    chk("refill_100", inst_data_o, 32'hA000_0100);
    chk("conf_mcnt", miss_count_o, 32'd5);

    // Flush in IDLE.
    cyc;
    inst_addr_i = 32'h40;
    #1;
    chk("pre_fl_hit", inst_valid_o, 1'b1);
    cyc;
    mem_fc = 1'b1;
    #1;
    chk("fl_vld", inst_valid_o, 1'b0);
    cyc;
    mem_fc = 1'b0;
    #1;
    chk("fl_blocked_rd", rd_o, 1'b0);
    chk("post_fl_miss", inst_valid_o, 1'b0);
    cyc;
    chk("post_fl_rd", rd_o, 1'b1);
    chk("post_fl_mcnt", miss_count_o, 32'd6);
    ack_i = 1'b1; data_i = mk_line(32'h40);
    cyc;
    ack_i = 1'b0;
    #1;
    chk("post_fl_fill", inst_data_o, 32'hA000_0040);

    // Flush during REFILL of 0x80, then flush coinciding with ack.
    cyc;
    inst_addr_i = 32'h80;
    #1;
    chk("k_miss", inst_valid_o, 1'b0);
    cyc;
    chk("k_rd", rd_o, 1'b1);
    chk("k_mcnt", miss_count_o, 32'd7);
    cyc;
    cyc;
    mem_fc = 1'b1;
    #1;
    chk("k_fl_vld", inst_valid_o, 1'b0);
    cyc;
    mem_fc = 1'b0;
    chk("k_rd_hold", rd_o, 1'b1);
    ack_i = 1'b1; data_i = mk_line(32'h80);
    cyc;
    ack_i = 1'b0;
    #1;
    chk("k_rd_drop", rd_o, 1'b0);
    chk("k_discard", inst_valid_o, 1'b0);
    cyc;
    chk("k_rereq", rd_o, 1'b1);
    chk("k_mcnt2", miss_count_o, 32'd8);
    ack_i = 1'b1; mem_fc = 1'b1;
    cyc;
    ack_i = 1'b0; mem_fc = 1'b0;
    #1;
    chk("ka_rd_drop", rd_o, 1'b0);
    chk("ka_discard", inst_valid_o, 1'b0);
    cyc;
    chk("ka_rereq", rd_o, 1'b1);
    chk("ka_mcnt", miss_count_o, 32'd9);
    ack_i = 1'b1;
    cyc;
    ack_i = 1'b0;
    #1;
    chk("ka_fill", inst_data_o, 32'hA000_0080);

    // Reset during a refill of 0xC0; ack arrives after release.
    cyc;
    inst_addr_i = 32'hC0;
    cyc;
    chk("r_rd", rd_o, 1'b1);
    #2;
    rst = 1'b1; inst_addr_i = 32'h80;
    #1;
    chk("r_rd_async", rd_o, 1'b0);
    chk("r_addr", addr_o, 32'h0);
    chk("r_hcnt", hit_count_o, 32'h0);
    chk("r_mcnt", miss_count_o, 32'h0);
    chk("r_vld", inst_valid_o, 1'b0);
    chk("r_data", inst_data_o, 32'h0);
    cyc;
    rst = 1'b0; inst_addr_i = 32'hC0;
    ack_i = 1'b1; data_i = mk_line(32'hC0);
    #1;
    chk("r_stray_vld", inst_valid_o, 1'b0);
    cyc;
    ack_i = 1'b0;
    #1;
    chk("r_next_miss", inst_valid_o, 1'b0);
    chk("r_next_rd", rd_o, 1'b1);
    chk("r_next_addr", addr_o, 32'hC0);
    chk("r_next_mcnt", miss_count_o, 32'd1);
    cyc;
    ack_i = 1'b1;
    cyc;
    ack_i = 1'b0;
    #1;
    chk("r_fill", inst_data_o, 32'hA000_00C0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
